// File: rtl/branch_resolve_unit.sv
// ID-stage conditional branch resolution with a 2-bit saturating-counter PHT
// for IF prediction and saturating retired-branch/mispredict statistics.
module branch_resolve_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PHT_DEPTH = 64,
  parameter logic [1:0]  PHT_INIT  = 2'b01,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  output logic             if_pred_taken_o,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic             id_flush,
  input  logic [5:0]       id_op,
  input  logic [4:0]       id_rt,
  input  logic [WIDTH-1:0] id_a,
  input  logic [WIDTH-1:0] id_b,
  input  logic [31:0]      id_pc,
  input  logic             id_pred_taken,
  output logic             is_branch_o,
  output logic             taken_o,
  output logic             link_o,
  output logic             mispredict_o,
  output logic [CNT_W-1:0] stat_branches_o,
  output logic [CNT_W-1:0] stat_mispredicts_o
);

  localparam int unsigned IDX = $clog2(PHT_DEPTH);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  logic [1:0]       pht_q [PHT_DEPTH];
  logic [1:0]       pht_d;
  logic [CNT_W-1:0] stat_br_q, stat_br_d;
  logic [CNT_W-1:0] stat_mp_q, stat_mp_d;
  logic [IDX-1:0]   if_idx, id_idx;
  logic             a_neg, a_zero, retire;

  assign if_idx = if_pc[IDX+1:2];
  assign id_idx = id_pc[IDX+1:2];

  // PC bits outside the index field are deliberately ignored (aliasing allowed).
  logic unused_pc_lo;
  assign unused_pc_lo = ^{if_pc[1:0], id_pc[1:0]};
  if (IDX + 2 < 32) begin : g_pc_hi
    logic unused_pc_hi;
    assign unused_pc_hi = ^{if_pc[31:IDX+2], id_pc[31:IDX+2]};
  end

  assign if_pred_taken_o = pht_q[if_idx][1];

  assign a_neg  = id_a[WIDTH-1];
  assign a_zero = (id_a == '0);

  always_comb begin
    is_branch_o = 1'b0;
    taken_o     = 1'b0;
    link_o      = 1'b0;
    case (id_op)
      OP_BEQ:  begin is_branch_o = 1'b1; taken_o = (id_a == id_b);    end
      OP_BNE:  begin is_branch_o = 1'b1; taken_o = (id_a != id_b);    end
      OP_BLEZ: begin is_branch_o = 1'b1; taken_o = a_neg | a_zero;    end
      OP_BGTZ: begin is_branch_o = 1'b1; taken_o = ~a_neg & ~a_zero;  end
      OP_REGIMM: begin
        case (id_rt)
          5'b00000, 5'b10000: begin
            is_branch_o = 1'b1; taken_o = a_neg;  link_o = id_rt[4];
          end
          5'b00001, 5'b10001: begin
            is_branch_o = 1'b1; taken_o = ~a_neg; link_o = id_rt[4];
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign mispredict_o = id_valid & is_branch_o & (taken_o != id_pred_taken);
  assign retire       = id_valid & is_branch_o & ~id_stall & ~id_flush;

  always_comb begin
    pht_d = pht_q[id_idx];
    if (taken_o) begin
      if (pht_q[id_idx] != 2'b11) pht_d = pht_q[id_idx] + 2'd1;
    end else begin
      if (pht_q[id_idx] != 2'b00) pht_d = pht_q[id_idx] - 2'd1;
    end
    stat_br_d = (stat_br_q == '1) ? stat_br_q : stat_br_q + CNT_W'(1);
    stat_mp_d = (stat_mp_q == '1) ? stat_mp_q : stat_mp_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PHT_DEPTH; i++) pht_q[i] <= PHT_INIT;
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (retire) begin
      pht_q[id_idx] <= pht_d;
      stat_br_q     <= stat_br_d;
      if (mispredict_o) stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mp_q;

endmodule
